return_addr_stack: RTL
======================

Name: return_addr_stack

Overview:
- Return-address stack (RAS) for the frontend. It consumes the call/return classification that instruction scanning produces for each fetched instruction.
- Pushes the link address (pc_i + 2 or + 4) on a call and pops the predicted target on a return.
- Sits between the predecode/scan stage and next-PC selection.
- Circular storage: on overflow the oldest entry is silently overwritten.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- VLEN, 64, address width in bits.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- flush_i  input  1  discard all entries (frontend redirect / fence.i).
- push_i  input  1  call detected (rvi_call or rvc_call).
- pop_i  input  1  return detected (rvi_return or rvc_return).
- pc_i  input  VLEN  address of the call instruction.
- is_rvc_i  input  1  call instruction is compressed.
- top_addr_o  output  VLEN  predicted return address (current top entry).
- top_valid_o  output  1  stack non-empty; top_addr_o is meaningful.
- count_o  output  $clog2(DEPTH)+1  number of valid entries.
- full_o  output  1  count_o == DEPTH.

Behaviour:
- Storage:
  - DEPTH x VLEN register array, tos pointer ($clog2(DEPTH) bits, wraps modulo DEPTH), count register.
  - top_addr_o = entry[tos], registered-state read, no combinational path from inputs.
- Link address: pc_i + (is_rvc_i ? 2 : 4), VLEN-bit add, carry out discarded (wraps at 2^VLEN).
- Reset (rst_i=1 at a clock edge): all entries 0, tos=0, count=0. After reset: top_addr_o=0, top_valid_o=0, count_o=0, full_o=0. Reset has priority over every other input.
- Priority per cycle: rst_i > flush_i > push/pop.
- flush_i=1: count=0. tos and entry contents are unchanged. push_i/pop_i in the same cycle are ignored.
- push_i=1, pop_i=0:
  - tos=tos+1 (wrap) and entry[tos+1]=link address.
  - count=min(count+1, DEPTH).
  - When full: the oldest entry is overwritten; count stays DEPTH; this is an overflow event.
- pop_i=1, push_i=0:
  - count>0: tos=tos-1 (wrap), count=count-1. The popped entry's contents are left unchanged.
  - count==0: no state change; this is an underflow event.
- push_i=1, pop_i=1 (return-and-call, e.g. jalr ra,ra):
  - count>0: entry[tos]=link address; tos and count unchanged.
  - count==0: treated as a plain push (count becomes 1).
- Latency: every update is visible on the outputs the cycle after the triggering edge. The current-cycle pop target is top_addr_o before the edge.
- top_valid_o = (count != 0). full_o = (count == DEPTH).
- Inputs are single-cycle pulses with no handshake; the block accepts one operation per cycle and never stalls.

Optional Feature:
- Macro: RAS_EVENT_CNT_EN.
- When defined, two extra output ports:
  - ovf_cnt_o (16 bits): saturating count of overflow events.
  - unf_cnt_o (16 bits): saturating count of underflow events.
- Both counters:
  - reset to 0 on rst_i;
  - are not cleared by flush_i;
  - hold at 16'hFFFF once reached;
  - do not increment on events suppressed by flush_i.
- When undefined, the ports and counters are absent and the functional behaviour is identical.

Test Plan:
- Reset then idle:
  - Expect top_valid_o=0, count_o=0, full_o=0, top_addr_o=0.
- Basic push/pop:
  - push pc_i=0x1000, is_rvc_i=0; next cycle expect top_addr_o=0x1004, count_o=1.
  - push pc_i=0x2000, is_rvc_i=1; expect top_addr_o=0x2002, count_o=2.
  - pop; expect top_addr_o=0x1004, count_o=1.
  - pop; expect top_valid_o=0.
- Overflow (DEPTH=4):
  - Push links 0x104, 0x204, 0x304, 0x404, 0x504; expect full_o=1, count_o=4, top_addr_o=0x504.
  - Four pops return 0x504, 0x404, 0x304, 0x204; fifth pop is an underflow with no state change.
  - With RAS_EVENT_CNT_EN: ovf_cnt_o=1, unf_cnt_o=1.
- Simultaneous push+pop:
  - Stack holds [0x1004, 0x2004]; assert push+pop with pc_i=0x3000, is_rvc_i=0; expect top_addr_o=0x3004, count_o=2.
  - Then pop; expect top_addr_o=0x1004.
- Flush priority:
  - Stack holds 3 entries; assert flush_i with push_i=1; expect count_o=0, top_valid_o=0.
  - Subsequent push pc_i=0x40 yields top_addr_o=0x44, count_o=1.
- Reset mid-operation and address wrap:
  - Assert rst_i together with push_i; expect all outputs at reset values.
  - Push pc_i=2^64-2 with is_rvc_i=1; expect top_addr_o=0.

Source files
------------

// File: rtl/return_addr_stack.sv
// Return-address stack: circular link-address storage for next-PC prediction.
// Optional RAS_EVENT_CNT_EN adds saturating overflow/underflow event counters.
module return_addr_stack #(
  parameter int DEPTH = 4,
  parameter int VLEN  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [VLEN-1:0]            pc_i,
  input  logic                       is_rvc_i,
`ifdef RAS_EVENT_CNT_EN
  output logic [15:0]                ovf_cnt_o,
  output logic [15:0]                unf_cnt_o,
`endif
  output logic [VLEN-1:0]            top_addr_o,
  output logic                       top_valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [VLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   tos;
  logic [PW-1:0]   tos_inc;
  logic [PW-1:0]   tos_dec;
  logic [CW-1:0]   count;
  logic [VLEN-1:0] link;
  logic            empty;
  logic            full;
  logic            do_push;
  logic            do_swap;
  logic            do_pop;

  assign link    = pc_i + (is_rvc_i ? VLEN'(2) : VLEN'(4));
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign tos_inc = tos + PW'(1);
  assign tos_dec = tos - PW'(1);

  // push+pop on an empty stack degenerates to a plain push
  assign do_push = push_i && (!pop_i || empty);
  assign do_swap = push_i && pop_i && !empty;
  assign do_pop  = pop_i && !push_i && !empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      tos   <= '0;
      count <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else if (do_push) begin
      tos          <= tos_inc;
      mem[tos_inc] <= link;
      if (!full) count <= count + CW'(1);
    end else if (do_swap) begin
      mem[tos] <= link;
    end else if (do_pop) begin
      tos   <= tos_dec;
      count <= count - CW'(1);
    end
  end

  assign top_addr_o  = mem[tos];
  assign top_valid_o = !empty;
  assign count_o     = count;
  assign full_o      = full;

`ifdef RAS_EVENT_CNT_EN
  logic ovf_evt;
  logic unf_evt;

  assign ovf_evt = !flush_i && push_i && !pop_i && full;
  assign unf_evt = !flush_i && pop_i && !push_i && empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_cnt_o <= '0;
      unf_cnt_o <= '0;
    end else begin
      if (ovf_evt && ovf_cnt_o != 16'hFFFF)
        ovf_cnt_o <= ovf_cnt_o + 16'd1;
      if (unf_evt && unf_cnt_o != 16'hFFFF)
        unf_cnt_o <= unf_cnt_o + 16'd1;
    end
  end
`endif

endmodule
